// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: opcodes, ALU/mux
// select codes, the FSM state type and the packed control word.
package mips_ctrl_pkg;

    localparam int OPC_W   = 6;
    localparam int ALUOP_W = 3;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    typedef struct packed {
        logic               pc_write;
        logic               branch;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               ir_write;
        logic               mem_to_reg;
        logic               reg_dst;
        logic               reg_write;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [ALUOP_W-1:0] alu_op;
        logic [1:0]         pc_src;
        logic               illegal_op;
        logic               instr_done;
    } ctrl_word_t;

    function automatic logic is_supported(input logic [OPC_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)   || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/mem_ready towards the controller,
// mux selects, write enables and status pulses back to the datapath.
interface multicycle_control_if;

    logic [mips_ctrl_pkg::OPC_W-1:0]   opcode;
    logic                              mem_ready;
    logic                              PCWrite;
    logic                              Branch;
    logic                              IorD;
    logic                              MemRead;
    logic                              MemWrite;
    logic                              IRWrite;
    logic                              MemToReg;
    logic                              RegDst;
    logic                              RegWrite;
    logic                              ALUSrcA;
    logic [1:0]                        ALUSrcB;
    logic [mips_ctrl_pkg::ALUOP_W-1:0] ALUOp;
    logic [1:0]                        PCSrc;
    logic                              illegal_op;
    logic                              instr_done;
    logic [3:0]                        state_dbg;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
               illegal_op, instr_done, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemToReg,
               RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc,
               illegal_op, instr_done, state_dbg
    );

endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational state -> control word decoder. Only the FETCH strobes and the
// MEMWR retire pulse look at mem_ready; illegal_op is supplied by the top.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic       mem_ready,
    output ctrl_word_t ctrl
);

    always_comb begin
        // NOTE: default the whole word first so every path assigns every field; no latches.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.iord       = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_B;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.branch     = 1'b1;
                ctrl.pc_src     = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: state and latched-opcode registers plus
// next-state logic; the control word comes from multicycle_ctrl_decode.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    multicycle_control_if.master bus
);

    state_e           state_q, state_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic             illegal;
    ctrl_word_t       dec_ctrl;
    ctrl_word_t       ctrl;

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        illegal  = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = bus.opcode;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            // The live opcode may already belong to the next instruction here.
            S_MEMADR: begin
                if (opcode_q == OP_LW)      state_d = S_MEMRD;
                else if (opcode_q == OP_SW) state_d = S_MEMWR;
                else                        state_d = S_FETCH;
            end
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (dec_ctrl)
    );

    // Reset blanks every output combinationally so an aborted access stops at once.
    always_comb begin
        ctrl            = dec_ctrl;
        ctrl.illegal_op = illegal;
        if (rst) ctrl = '0;
    end

    assign bus.PCWrite    = ctrl.pc_write;
    assign bus.Branch     = ctrl.branch;
    assign bus.IorD       = ctrl.iord;
    assign bus.MemRead    = ctrl.mem_read;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.MemToReg   = ctrl.mem_to_reg;
    assign bus.RegDst     = ctrl.reg_dst;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUOp      = ctrl.alu_op;
    assign bus.PCSrc      = ctrl.pc_src;
    assign bus.illegal_op = ctrl.illegal_op;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.state_dbg  = rst ? 4'd0 : state_q;

endmodule
